// File: rtl/rom_dl_pkg.sv
// Shared types and widths for the ROM download packer: FSM states, address and data widths,
// and the layout of one FIFO entry.
package rom_dl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } dl_state_t;

    localparam int BYTE_AW = 25;
    localparam int WORD_AW = 24;
    localparam int DATA_W  = 16;
    localparam int ENTRY_W = WORD_AW + DATA_W;

    // A FIFO entry carries the word address in the upper bits and the data word in the lower bits.
    function automatic logic [ENTRY_W-1:0] mk_entry(input logic [WORD_AW-1:0] addr,
                                                    input logic [DATA_W-1:0]  data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/dl_word_fifo.sv
// Small word FIFO with two write ports, so that a stale byte and a new word can be queued
// in one cycle. Writes beyond the free space are dropped and reported on o_drop.
module dl_word_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             i_clr,
    input  logic             i_wr0,
    input  logic [WIDTH-1:0] i_wdata0,
    input  logic             i_wr1,
    input  logic [WIDTH-1:0] i_wdata1,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [AW:0]      r_count;

    logic [AW:0]   w_free;
    logic          w_acc0, w_acc1, w_pop;
    logic [AW-1:0] w_wptr1;

    assign w_free  = (AW+1)'(DEPTH) - r_count;
    assign w_acc0  = i_wr0 && (w_free != '0);
    assign w_acc1  = i_wr1 && (w_acc0 ? (w_free > (AW+1)'(1)) : (w_free != '0));
    assign w_pop   = i_rd && (r_count != '0);
    assign w_wptr1 = r_wptr + AW'(w_acc0);
    assign o_drop  = !i_clr && ((i_wr0 && !w_acc0) || (i_wr1 && !w_acc1));
    assign o_empty = (r_count == '0);
    // The head must be visible in the same cycle it is requested, so the read is combinational.
    assign o_rdata = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (srst || i_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_acc0) + AW'(w_acc1);
            r_rptr  <= r_rptr + AW'(w_pop);
            r_count <= r_count + (AW+1)'(w_acc0) + (AW+1)'(w_acc1) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc0) r_mem[r_wptr]  <= i_wdata0;
        if (w_acc1) r_mem[w_wptr1] <= i_wdata1;
    end

endmodule

// File: rtl/rom_dl_packer.sv
// Packs the byte-wide ioctl download stream into 16-bit SDRAM write words, queued through a
// small FIFO, and tracks the download lifecycle (load, flush, drain, done).
module rom_dl_packer
    import rom_dl_pkg::*;
#(
    parameter int INDEX      = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                ioctl_downl,
    input  logic [7:0]          ioctl_index,
    input  logic                ioctl_wr,
    input  logic [BYTE_AW-1:0]  ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    output logic                sdr_req,
    output logic [WORD_AW-1:0]  sdr_addr,
    output logic [DATA_W-1:0]   sdr_din,
    input  logic                sdr_ack,
    output logic                busy,
    output logic                rom_loaded,
    output logic                overflow
);
    dl_state_t          r_state, w_state_next;
    logic               r_downl_d;
    logic               r_pend;
    logic [7:0]         r_pend_lo;
    logic [WORD_AW-1:0] r_pend_waddr;
    logic               r_rom_loaded, r_overflow;

    logic               w_idx_ok, w_dl_rise, w_dl_fall, w_byte_ok, w_start;
    logic [WORD_AW-1:0] w_waddr;
    logic               w_wr0, w_wr1, w_pend_set, w_pend_clr;
    logic [ENTRY_W-1:0] w_wd0, w_wd1, w_stale, w_head;
    logic               w_empty, w_drop;

    assign w_idx_ok  = (ioctl_index == 8'(INDEX));
    assign w_dl_rise = ioctl_downl && !r_downl_d && w_idx_ok;
    assign w_dl_fall = !ioctl_downl && r_downl_d;
    assign w_byte_ok = ioctl_wr && ioctl_downl && w_idx_ok;
    assign w_waddr   = ioctl_addr[BYTE_AW-1:1];
    assign w_stale   = mk_entry(r_pend_waddr, {8'h00, r_pend_lo});

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_dl_rise) begin w_state_next = ST_LOAD; w_start = 1'b1; end
            ST_LOAD:  if (w_dl_fall) w_state_next = ST_FLUSH;
            ST_FLUSH: begin
                w_state_next = ST_DRAIN;
                if (w_dl_rise) begin w_state_next = ST_LOAD; w_start = 1'b1; end
            end
            ST_DRAIN: begin
                if (w_dl_rise) begin w_state_next = ST_LOAD; w_start = 1'b1; end
                else if (w_empty) w_state_next = ST_DONE;
            end
            ST_DONE:  if (w_dl_rise) begin w_state_next = ST_LOAD; w_start = 1'b1; end
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Byte packer: an odd byte that cannot pair with the pending low byte pushes both words at once.
    always_comb begin
        w_wr0      = 1'b0;
        w_wr1      = 1'b0;
        w_wd0      = '0;
        w_wd1      = '0;
        w_pend_set = 1'b0;
        w_pend_clr = 1'b0;
        if (r_state == ST_LOAD && w_byte_ok) begin
            if (!ioctl_addr[0]) begin
                w_pend_set = 1'b1;
                if (r_pend && r_pend_waddr != w_waddr) begin
                    w_wr0 = 1'b1;
                    w_wd0 = w_stale;
                end
            end else begin
                w_pend_clr = 1'b1;
                w_wr0      = 1'b1;
                if (r_pend && r_pend_waddr == w_waddr) begin
                    w_wd0 = mk_entry(w_waddr, {ioctl_dout, r_pend_lo});
                end else if (r_pend) begin
                    w_wd0 = w_stale;
                    w_wr1 = 1'b1;
                    w_wd1 = mk_entry(w_waddr, {ioctl_dout, 8'h00});
                end else begin
                    w_wd0 = mk_entry(w_waddr, {ioctl_dout, 8'h00});
                end
            end
        end else if (r_state == ST_FLUSH && !w_dl_rise && r_pend) begin
            w_pend_clr = 1'b1;
            w_wr0      = 1'b1;
            w_wd0      = w_stale;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_downl_d    <= 1'b1;   // a download already high at reset is not a new start
            r_pend       <= 1'b0;
            r_pend_lo    <= '0;
            r_pend_waddr <= '0;
            r_rom_loaded <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_downl_d <= ioctl_downl;
            if (w_pend_set) begin
                r_pend       <= 1'b1;
                r_pend_lo    <= ioctl_dout;
                r_pend_waddr <= w_waddr;
            end else if (w_pend_clr || w_start) begin
                r_pend <= 1'b0;
            end
            if (w_start)
                r_rom_loaded <= 1'b0;
            else if (w_state_next == ST_DONE && r_state != ST_DONE)
                r_rom_loaded <= 1'b1;
            if (w_start)
                r_overflow <= 1'b0;
            else if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    dl_word_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_sys),
        .srst     (reset),
        .i_clr    (w_start),
        .i_wr0    (w_wr0),
        .i_wdata0 (w_wd0),
        .i_wr1    (w_wr1),
        .i_wdata1 (w_wd1),
        .i_rd     (sdr_ack),
        .o_rdata  (w_head),
        .o_empty  (w_empty),
        .o_drop   (w_drop)
    );

    assign sdr_req    = !w_empty;
    assign sdr_addr   = w_empty ? '0 : w_head[ENTRY_W-1:DATA_W];
    assign sdr_din    = w_empty ? '0 : w_head[DATA_W-1:0];
    assign busy       = (r_state == ST_LOAD) || (r_state == ST_FLUSH) || (r_state == ST_DRAIN);
    assign rom_loaded = r_rom_loaded;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_rom_dl_packer.sv
// Scoreboard bench for rom_dl_packer: directed byte streams push expected SDRAM words into a
// queue; a monitor pops and compares each word the DUT hands over on req/ack.
module tb_rom_dl_packer;
    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_downl;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        sdr_req;
    logic [23:0] sdr_addr;
    logic [15:0] sdr_din;
    logic        sdr_ack;
    logic        busy, rom_loaded, overflow;

    int          checks = 0;
    int          errors = 0;
    logic [39:0] sb_q[$];

    always #5 clk_sys = ~clk_sys;

    rom_dl_packer #(.INDEX(0), .FIFO_DEPTH(4)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ioctl_downl (ioctl_downl),
        .ioctl_index (ioctl_index),
        .ioctl_wr    (ioctl_wr),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .sdr_req     (sdr_req),
        .sdr_addr    (sdr_addr),
        .sdr_din     (sdr_din),
        .sdr_ack     (sdr_ack),
        .busy        (busy),
        .rom_loaded  (rom_loaded),
        .overflow    (overflow)
    );

    // Monitor: a word is consumed at the next rising edge whenever req and ack are both high.
    always @(negedge clk_sys) begin
        if (!reset && sdr_req && sdr_ack) begin
            logic [39:0] exp_w;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got addr=%06h din=%04h required none", sdr_addr, sdr_din);
            end else begin
                exp_w = sb_q.pop_front();
                if ({sdr_addr, sdr_din} !== exp_w) begin
                    errors++;
                    $display("FAIL sdr_word: got addr=%06h din=%04h required addr=%06h din=%04h",
                             sdr_addr, sdr_din, exp_w[39:16], exp_w[15:0]);
                end else begin
                    $display("write addr=%06h din=%04h ok", sdr_addr, sdr_din);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp_v);
        end
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic expect_word(input logic [23:0] a, input logic [15:0] d);
        sb_q.push_back({a, d});
    endtask

    task automatic start_dl();
        ioctl_index = 8'd0;
        ioctl_downl = 1'b1;
        tick();
    endtask

    task automatic end_dl();
        ioctl_downl = 1'b0;
        tick();
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!rom_loaded && n < 100) begin
            tick();
            n++;
        end
        chk(nm, {63'd0, rom_loaded}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        ioctl_downl = 1'b1;    // already high during reset: must not count as a start
        ioctl_index = 8'd0;
        ioctl_wr    = 1'b0;
        ioctl_addr  = '0;
        ioctl_dout  = '0;
        sdr_ack     = 1'b0;
        tick(); tick();
        chk("rst_req",      {63'd0, sdr_req}, 64'd0);
        chk("rst_addr",     {40'd0, sdr_addr}, 64'd0);
        chk("rst_din",      {48'd0, sdr_din}, 64'd0);
        chk("rst_busy",     {63'd0, busy}, 64'd0);
        chk("rst_loaded",   {63'd0, rom_loaded}, 64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
        reset = 1'b0;
        tick(); tick(); tick();
        chk("held_downl_ignored", {63'd0, busy}, 64'd0);
        ioctl_downl = 1'b0;
        tick();

        // Basic pair 0x12@0, 0x34@1
        sdr_ack = 1'b1;
        start_dl();
        chk("load_busy", {63'd0, busy}, 64'd1);
        wr_byte(25'd0, 8'h12);
        expect_word(24'd0, 16'h3412);
        wr_byte(25'd1, 8'h34);
        end_dl();
        wait_done("basic_done");
        chk("basic_sb_empty", 64'(sb_q.size()), 64'd0);
        chk("basic_overflow", {63'd0, overflow}, 64'd0);

        // Strobe and download edge with the wrong index are ignored in DONE
        ioctl_index = 8'd1;
        ioctl_downl = 1'b1;
        wr_byte(25'd0, 8'hEE);
        tick(); tick();
        chk("bad_idx_busy",   {63'd0, busy}, 64'd0);
        chk("bad_idx_loaded", {63'd0, rom_loaded}, 64'd1);
        chk("bad_idx_req",    {63'd0, sdr_req}, 64'd0);
        ioctl_downl = 1'b0;
        ioctl_index = 8'd0;
        tick();

        // Odd-length image: last byte flushed as {00, byte}
        start_dl();
        chk("restart_clears_loaded", {63'd0, rom_loaded}, 64'd0);
        wr_byte(25'd0, 8'hA1);
        expect_word(24'd0, 16'hB2A1);
        wr_byte(25'd1, 8'hB2);
        wr_byte(25'd2, 8'hC3);
        expect_word(24'd1, 16'h00C3);
        end_dl();
        wait_done("odd_done");
        chk("odd_sb_empty", 64'(sb_q.size()), 64'd0);

        // Stale pending bytes, lone odd bytes, address wrap, then a back-to-back stream
        start_dl();
        wr_byte(25'd4, 8'h11);
        expect_word(24'd2, 16'h0011);
        expect_word(24'd3, 16'h2200);
        wr_byte(25'd7, 8'h22);
        expect_word(24'd4, 16'h3300);
        wr_byte(25'd9, 8'h33);
        wr_byte(25'd10, 8'h44);
        expect_word(24'd5, 16'h0044);
        wr_byte(25'd12, 8'h55);
        expect_word(24'd6, 16'h6655);
        wr_byte(25'd13, 8'h66);
        wr_byte(25'h1FFFFFE, 8'h77);
        expect_word(24'hFFFFFF, 16'h8877);
        wr_byte(25'h1FFFFFF, 8'h88);
        for (int i = 0; i < 16; i++) begin
            if (i[0]) expect_word(24'(8'h80 + 8'(i / 2)), {8'(8'hA0 + i), 8'(8'hA0 + i - 1)});
            wr_byte(25'(12'h100 + i), 8'(8'hA0 + i));
        end
        end_dl();
        wait_done("stream_done");
        chk("stream_sb_empty", 64'(sb_q.size()), 64'd0);

        // Overflow: ack held low, ten words into a four-entry FIFO
        sdr_ack = 1'b0;
        start_dl();
        chk("start_clears_overflow", {63'd0, overflow}, 64'd0);
        expect_word(24'd0, 16'h0100);
        expect_word(24'd1, 16'h0302);
        expect_word(24'd2, 16'h0504);
        expect_word(24'd3, 16'h0706);
        for (int k = 0; k < 20; k++) wr_byte(25'(k), 8'(k));
        chk("ovf_flag", {63'd0, overflow}, 64'd1);
        chk("ovf_req",  {63'd0, sdr_req}, 64'd1);
        chk("ovf_head", {24'd0, sdr_addr, sdr_din}, {24'd0, 24'd0, 16'h0100});
        end_dl();
        tick(); tick(); tick();
        chk("drain_busy",   {63'd0, busy}, 64'd1);
        chk("drain_loaded", {63'd0, rom_loaded}, 64'd0);
        sdr_ack = 1'b1;
        wait_done("ovf_done");
        chk("ovf_sb_empty", 64'(sb_q.size()), 64'd0);
        chk("ovf_sticky",   {63'd0, overflow}, 64'd1);

        // Reset in DRAIN with a pending request
        sdr_ack = 1'b0;
        start_dl();
        expect_word(24'h10, 16'h0201);
        wr_byte(25'h20, 8'h01);
        wr_byte(25'h21, 8'h02);
        end_dl();
        tick(); tick(); tick();
        chk("pre_rst_req",  {63'd0, sdr_req}, 64'd1);
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_req",    {63'd0, sdr_req}, 64'd0);
        chk("mid_rst_addr",   {40'd0, sdr_addr}, 64'd0);
        chk("mid_rst_busy",   {63'd0, busy}, 64'd0);
        chk("mid_rst_loaded", {63'd0, rom_loaded}, 64'd0);
        reset = 1'b0;
        sb_q.delete();
        tick();
        sdr_ack = 1'b1;
        start_dl();
        expect_word(24'd1, 16'hA55A);
        wr_byte(25'd2, 8'h5A);
        wr_byte(25'd3, 8'hA5);
        end_dl();
        wait_done("post_rst_done");
        chk("post_rst_sb_empty", 64'(sb_q.size()), 64'd0);

        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
